mode_sequencer: RTL and testbench

Parametrised successor to the single-register mode controller: it selects one of `NUM_MODES` operating modes from a prioritised request vector. Unlike the previous controller, it does not switch immediately. It waits for the downstream datapath to drain (`busy` low) or for a bounded timeout, supports request lockout, and reports a one-cycle change pulse. It sits between the button/command decoder and the edit/play/raw datapaths.

---
 rtl/mode_sequencer.sv | 156 +++++++++++++++
 tb/tb_mode_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mode_sequencer.sv
// Prioritised mode selector that drains the downstream datapath (or times out) before committing a mode switch.
// Optional return-to-previous-mode feature is enabled by defining MODE_SEQ_RETURN_EN.
module mode_sequencer #(
    parameter int NUM_MODES     = 3,
    parameter int MODE_W        = 2,
    parameter int RESET_MODE    = 0,
    parameter int DRAIN_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_MODES-1:0] req,
    input  logic                 busy,
    input  logic                 lock,
`ifdef MODE_SEQ_RETURN_EN
    input  logic                 ret,
    output logic [MODE_W-1:0]    prev_mode,
`endif
    output logic [MODE_W-1:0]    mode,
    output logic [MODE_W-1:0]    target,
    output logic                 pending,
    output logic                 mode_changed,
    output logic                 timeout
);

    localparam int CNT_W = (DRAIN_TIMEOUT < 1) ? 1 : $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DRAIN_TIMEOUT);
    localparam logic [MODE_W-1:0] MODE_RST = MODE_W'(RESET_MODE);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [MODE_W-1:0]  mode_next, target_next;
    logic               changed_next, timeout_next;
    logic               commit;
    logic               win_valid;
    logic [MODE_W-1:0]  win_idx;
    logic               ret_go;
    logic [MODE_W-1:0]  ret_target;

    // Scanning from the top down lets the lowest set index overwrite the rest.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = NUM_MODES - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_valid = 1'b1;
                win_idx   = MODE_W'(i);
            end
        end
    end

`ifdef MODE_SEQ_RETURN_EN
    logic [MODE_W-1:0] prev_next;

    always_comb begin
        ret_go     = !lock && !win_valid && ret && (prev_mode != mode);
        ret_target = prev_mode;
    end
`else
    always_comb begin
        ret_go     = 1'b0;
        ret_target = mode;
    end
`endif

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        mode_next    = mode;
        target_next  = target;
        changed_next = 1'b0;
        timeout_next = 1'b0;
        commit       = 1'b0;

        case (state)
            IDLE: begin
                if (!lock && win_valid && (win_idx != mode)) begin
                    target_next = win_idx;
                    cnt_next    = '0;
                    state_next  = DRAIN;
                end else if (ret_go) begin
                    target_next = ret_target;
                    cnt_next    = '0;
                    state_next  = DRAIN;
                end
            end
            DRAIN: begin
                if (!busy) begin
                    commit = 1'b1;
                end else if ((DRAIN_TIMEOUT != 0) && (cnt == CNT_MAX)) begin
                    commit       = 1'b1;
                    timeout_next = 1'b1;
                end else begin
                    if (cnt != CNT_MAX) begin
                        cnt_next = cnt + 1'b1;
                    end
                    // Retarget keeps the counter running so the overall wait stays bounded.
                    if (!lock && win_valid) begin
                        if (win_idx == mode) begin
                            target_next = mode;
                            state_next  = IDLE;
                        end else if (win_idx != target) begin
                            target_next = win_idx;
                        end
                    end
                end

                if (commit) begin
                    mode_next    = target;
                    changed_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef MODE_SEQ_RETURN_EN
    always_comb begin
        prev_next = commit ? mode : prev_mode;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_mode <= MODE_RST;
        end else begin
            prev_mode <= prev_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            mode         <= MODE_RST;
            target       <= MODE_RST;
            mode_changed <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            mode         <= mode_next;
            target       <= target_next;
            mode_changed <= changed_next;
            timeout      <= timeout_next;
        end
    end

    assign pending = (state == DRAIN);

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed self-checking bench for mode_sequencer with a short drain timeout.
// Return-to-previous checks are compiled in when MODE_SEQ_RETURN_EN is defined.
module tb_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic       busy;
    logic       lock;
    logic       ret;
    logic [1:0] mode;
    logic [1:0] target;
    logic       pending;
    logic       mode_changed;
    logic       timeout;
`ifdef MODE_SEQ_RETURN_EN
    logic [1:0] prev_mode;
`endif

    int vectors = 0;
    int errors  = 0;

    mode_sequencer #(
        .NUM_MODES    (3),
        .MODE_W       (2),
        .RESET_MODE   (0),
        .DRAIN_TIMEOUT(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .busy        (busy),
        .lock        (lock),
`ifdef MODE_SEQ_RETURN_EN
        .ret         (ret),
        .prev_mode   (prev_mode),
`endif
        .mode        (mode),
        .target      (target),
        .pending     (pending),
        .mode_changed(mode_changed),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic [2:0] q, input logic b,
                                 input logic l, input logic rt);
        rst  = r;
        req  = q;
        busy = b;
        lock = l;
        ret  = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs packed as {mode, target, pending, mode_changed, timeout}.
    task automatic checkOutput(input string tag, input logic [1:0] m, input logic [1:0] t,
                               input logic p, input logic mc, input logic to);
        logic [6:0] observed;
        logic [6:0] expected;
        observed = {mode, target, pending, mode_changed, timeout};
        expected = {m, t, p, mc, to};
        vectors++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed {mode,target,pend,chg,to}=%b_%b_%b%b%b expected %b_%b_%b%b%b",
                   tag, observed[6:5], observed[4:3], observed[2], observed[1], observed[0],
                   expected[6:5], expected[4:3], expected[2], expected[1], expected[0]);
        end
    endtask

`ifdef MODE_SEQ_RETURN_EN
    task automatic checkPrev(input string tag, input logic [1:0] exp_prev);
        vectors++;
        assert (prev_mode === exp_prev) else begin
            errors++;
            $error("[TB] FAIL %s: observed prev_mode=%0d expected %0d", tag, prev_mode, exp_prev);
        end
    endtask
`endif

    initial begin
        // Reset held two cycles with every request asserted.
        applyStimulus(1, 3'b111, 0, 0, 0);
        tick(); checkOutput("reset_1", 0, 0, 0, 0, 0);
        tick(); checkOutput("reset_2", 0, 0, 0, 0, 0);
`ifdef MODE_SEQ_RETURN_EN
        checkPrev("reset_prev", 0);
`endif
        applyStimulus(0, 3'b111, 0, 0, 0);
        tick(); checkOutput("reset_release", 0, 0, 0, 0, 0);

        // Priority winner 1 with busy low: two-edge switch.
        applyStimulus(0, 3'b110, 0, 0, 0);
        tick(); checkOutput("imm_enter", 0, 1, 1, 0, 0);
        applyStimulus(0, 3'b000, 0, 0, 0);
        tick(); checkOutput("imm_commit", 1, 1, 0, 1, 0);
        tick(); checkOutput("imm_pulse_end", 1, 1, 0, 0, 0);

        // Forced commit after DRAIN_TIMEOUT+1 busy edges.
        applyStimulus(0, 3'b100, 1, 0, 0);
        tick(); checkOutput("to_enter", 1, 2, 1, 0, 0);
        applyStimulus(0, 3'b000, 1, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            tick(); checkOutput($sformatf("to_wait_%0d", i), 1, 2, 1, 0, 0);
        end
        tick(); checkOutput("to_commit", 2, 2, 0, 1, 1);
        tick(); checkOutput("to_pulse_end", 2, 2, 0, 0, 0);

        // Back to mode 0.
        applyStimulus(0, 3'b001, 0, 0, 0);
        tick(); checkOutput("home_enter", 2, 0, 1, 0, 0);
        applyStimulus(0, 3'b000, 0, 0, 0);
        tick(); checkOutput("home_commit", 0, 0, 0, 1, 0);
        tick();

        // Retarget 2 -> 1 while busy, then release busy.
        applyStimulus(0, 3'b100, 1, 0, 0);
        tick(); checkOutput("rt_enter", 0, 2, 1, 0, 0);
        applyStimulus(0, 3'b010, 1, 0, 0);
        tick(); checkOutput("rt_retarget", 0, 1, 1, 0, 0);
        applyStimulus(0, 3'b000, 0, 0, 0);
        tick(); checkOutput("rt_commit", 1, 1, 0, 1, 0);
        tick(); checkOutput("rt_idle", 1, 1, 0, 0, 0);

        // Abort by re-requesting the current mode.
        applyStimulus(0, 3'b100, 1, 0, 0);
        tick(); checkOutput("ab_enter", 1, 2, 1, 0, 0);
        applyStimulus(0, 3'b010, 1, 0, 0);
        tick(); checkOutput("ab_abort", 1, 1, 0, 0, 0);
        applyStimulus(0, 3'b000, 1, 0, 0);
        tick(); checkOutput("ab_no_pulse", 1, 1, 0, 0, 0);

        // Locked requests in IDLE are not latched.
        applyStimulus(0, 3'b010, 0, 1, 0);
        tick(); checkOutput("lock_same", 1, 1, 0, 0, 0);
        applyStimulus(0, 3'b001, 0, 1, 0);
        tick(); checkOutput("lock_other", 1, 1, 0, 0, 0);
        applyStimulus(0, 3'b000, 0, 0, 0);
        tick(); checkOutput("lock_dropped", 1, 1, 0, 0, 0);

        // Lock raised mid-DRAIN does not cancel the switch.
        applyStimulus(0, 3'b001, 1, 0, 0);
        tick(); checkOutput("lk_enter", 1, 0, 1, 0, 0);
        applyStimulus(0, 3'b010, 1, 1, 0);
        tick(); checkOutput("lk_hold", 1, 0, 1, 0, 0);
        applyStimulus(0, 3'b000, 0, 1, 0);
        tick(); checkOutput("lk_commit", 0, 0, 0, 1, 0);
        applyStimulus(0, 3'b000, 0, 0, 0);
        tick(); checkOutput("lk_idle", 0, 0, 0, 0, 0);

        // Reset mid-DRAIN discards the switch.
        applyStimulus(0, 3'b100, 1, 0, 0);
        tick(); checkOutput("rd_enter", 0, 2, 1, 0, 0);
        applyStimulus(1, 3'b000, 1, 0, 0);
        tick(); checkOutput("rd_reset", 0, 0, 0, 0, 0);
        applyStimulus(0, 3'b000, 0, 0, 0);
        tick(); checkOutput("rd_after", 0, 0, 0, 0, 0);

        // The commit edge ignores a competing request.
        applyStimulus(0, 3'b100, 0, 0, 0);
        tick(); checkOutput("ci_enter", 0, 2, 1, 0, 0);
        applyStimulus(0, 3'b010, 0, 0, 0);
        tick(); checkOutput("ci_commit", 2, 2, 0, 1, 0);
        applyStimulus(0, 3'b000, 0, 0, 0);
        tick(); checkOutput("ci_idle", 2, 2, 0, 0, 0);

`ifdef MODE_SEQ_RETURN_EN
        checkPrev("ret_prev_before", 0);
        applyStimulus(0, 3'b000, 0, 0, 1);
        tick(); checkOutput("ret_enter", 2, 0, 1, 0, 0);
        applyStimulus(0, 3'b000, 0, 0, 0);
        tick(); checkOutput("ret_commit", 0, 0, 0, 1, 0);
        checkPrev("ret_prev_after", 2);
        applyStimulus(0, 3'b010, 0, 0, 1);
        tick(); checkOutput("ret_req_wins", 0, 1, 1, 0, 0);
        applyStimulus(0, 3'b000, 0, 0, 0);
        tick(); checkOutput("ret_req_commit", 1, 1, 0, 1, 0);
        checkPrev("ret_req_prev", 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
